// File: rtl/regfile_pkg.sv
// Shared defaults, dump sequencer state encoding and address helpers for the
// MIPS register file with debug dump.
package regfile_pkg;

  localparam int REGFILE_WIDTH = 32;
  localparam int REGFILE_DEPTH = 32;

  typedef enum logic {
    DS_IDLE,
    DS_SEND
  } dumpState_e;

  // Address width for a given depth; a single-entry file still needs one bit.
  function automatic int addrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit inRange(input int addr, input int depth);
    return (addr >= 0) && (addr < depth);
  endfunction

endpackage

// File: rtl/regfile_dump_seq.sv
// Debug dump sequencer: walks DUMP_LO..DUMP_HI and presents one registered
// beat per register over a valid/ready port.
module regfile_dump_seq
  import regfile_pkg::*;
#(
  parameter int WIDTH   = REGFILE_WIDTH,
  parameter int AW      = 5,
  parameter int DUMP_LO = 0,
  parameter int DUMP_HI = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dump_start,
  input  logic             dump_ready,
  output logic             dump_busy,
  output logic             dump_valid,
  output logic [AW-1:0]    dump_idx,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_last,
  output logic [AW-1:0]    fetchAddr,
  input  logic [WIDTH-1:0] fetchData
);

  dumpState_e state, nextState;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] beatData;
  logic             loadBeat;
  logic             atLast;

  assign atLast = (idx == AW'(DUMP_HI));

  // NOTE: every signal assigned in this block gets a default first, otherwise
  // paths that skip an assignment infer latches.
  always_comb begin
    nextState = state;
    loadBeat  = 1'b0;
    fetchAddr = AW'(DUMP_LO);
    unique case (state)
      DS_IDLE: begin
        if (dump_start) begin
          nextState = DS_SEND;
          loadBeat  = 1'b1;
        end
      end
      DS_SEND: begin
        fetchAddr = idx + AW'(1);
        if (dump_ready) begin
          if (atLast) nextState = DS_IDLE;
          else        loadBeat  = 1'b1;
        end
      end
      default: nextState = DS_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DS_IDLE;
      idx      <= '0;
      beatData <= '0;
    end else begin
      state <= nextState;
      // The beat is captured once and then held, so later writes to the same
      // register never disturb a stalled beat.
      if (loadBeat) begin
        idx      <= fetchAddr;
        beatData <= fetchData;
      end
    end
  end

  assign dump_busy  = (state == DS_SEND);
  assign dump_valid = dump_busy;
  assign dump_idx   = idx;
  assign dump_data  = beatData;
  assign dump_last  = dump_busy && atLast;

endmodule

// File: rtl/regfile_dump.sv
// General-purpose register file: two combinational read ports with
// write-to-read forwarding, one write port, and a debug dump sequencer.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int DUMP_LO  = 0,
  parameter int DUMP_HI  = DEPTH - 1,
  localparam int AW      = addrWidth(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             dump_start,
  output logic             dump_busy,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [AW-1:0]    dump_idx,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_last
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wrEffective;
  logic [AW-1:0]    seqAddr;
  logic [WIDTH-1:0] seqData;

  assign wrEffective = wr_en && inRange(int'(wr_addr), DEPTH) &&
                       !((ZERO_REG != 0) && (wr_addr == '0));

  // NOTE: this is a flop array rather than an inferred RAM, so resetting every
  // entry is intended and costs only the reset mux per flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wrEffective) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // One read function serves both decode ports and the dump fetch, so a dump
  // capture sees an in-flight write exactly like decode does.
  function automatic logic [WIDTH-1:0] fwdRead(input logic [AW-1:0] addr);
    if (wrEffective && (wr_addr == addr))
      return wr_data;
    else if (((ZERO_REG != 0) && (addr == '0)) || !inRange(int'(addr), DEPTH))
      return '0;
    else
      return mem[addr];
  endfunction

  always_comb begin
    rd_data1 = fwdRead(rd_addr1);
    rd_data2 = fwdRead(rd_addr2);
    seqData  = fwdRead(seqAddr);
  end

  regfile_dump_seq #(
    .WIDTH   (WIDTH),
    .AW      (AW),
    .DUMP_LO (DUMP_LO),
    .DUMP_HI (DUMP_HI)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .fetchAddr  (seqAddr),
    .fetchData  (seqData)
  );

endmodule
